// File: rtl/pwm_capture.sv
// PWM input measurement: recovers high-time, period and an 8-bit brightness
// (inverse log curve) from an asynchronous PWM pin, with constant-level timeout.
module pwm_capture #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [7:0]       bright,
  output logic             valid,
  output logic             stuck
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEEK = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // Timeout triggers on the clock where per would step onto CNT_MAX.
  localparam logic [CNT_W-1:0] TO_AT   = CNT_MAX - CNT_ONE;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d_q, rise, fall, timeout;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       per_q, per_d, hi_q, hi_d;
  logic [CNT_W-1:0]       high_q, high_d, period_q, period_d;
  logic [7:0]             bright_q, bright_d;
  logic                   valid_q, valid_d, stuck_q, stuck_d;

  function automatic logic [7:0] inv_map(input logic [CNT_W-1:0] h);
    logic [CNT_W-1:0] t;
    if (h < CNT_W'(64)) begin
      return h[7:0];
    end else if (h < CNT_W'(192)) begin
      t = (h - CNT_W'(64)) >> 1;
      return 8'd64 + t[7:0];
    end else if (h < CNT_W'(704)) begin
      t = (h - CNT_W'(192)) >> 3;
      return 8'd128 + t[7:0];
    end else if (h < CNT_W'(1727)) begin
      t = (h - CNT_W'(704)) >> 4;
      return 8'd192 + t[7:0];
    end else begin
      return 8'hFF;
    end
  endfunction

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign fall    = ~s & s_d_q;
  assign timeout = (per_q == TO_AT);

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    high_d   = high_q;
    period_d = period_q;
    bright_d = bright_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    if (!enable) begin
      state_d = ST_IDLE;
      per_d   = '0;
      hi_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEEK;
        ST_SEEK: begin
          if (rise) begin
            state_d = ST_HIGH;
            per_d   = CNT_ONE;
            hi_d    = CNT_ONE;
          end else if (!timeout) begin
            per_d = per_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!timeout) begin
            per_d = per_q + CNT_ONE;
            if (fall) state_d = ST_LOW;
            else      hi_d    = hi_q + CNT_ONE;
          end
        end
        default: begin
          if (rise) begin
            period_d = per_q;
            high_d   = hi_q;
            bright_d = inv_map(hi_q);
            stuck_d  = 1'b0;
            valid_d  = 1'b1;
            state_d  = ST_HIGH;
            per_d    = CNT_ONE;
            hi_d     = CNT_ONE;
          end else if (!timeout) begin
            per_d = per_q + CNT_ONE;
          end
        end
      endcase
      // A completing rise takes priority over the timeout on the same clock.
      if (state_q != ST_IDLE && timeout && !(rise && state_q != ST_HIGH)) begin
        valid_d  = 1'b1;
        stuck_d  = 1'b1;
        period_d = CNT_MAX;
        high_d   = s ? CNT_MAX : '0;
        bright_d = s ? 8'hFF : 8'h00;
        per_d    = '0;
        hi_d     = '0;
        state_d  = s ? ST_HIGH : ST_SEEK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      s_d_q    <= 1'b0;
      state_q  <= ST_IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      high_q   <= '0;
      period_q <= '0;
      bright_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q    <= s;
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      high_q   <= high_d;
      period_q <= period_d;
      bright_q <= bright_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign high_cnt   = high_q;
  assign period_cnt = period_q;
  assign bright     = bright_q;
  assign valid      = valid_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: expected reports are queued as stimulus is
// driven and compared whenever the block strobes valid.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n, enable, pwm_in;
  logic [11:0] high_cnt, period_cnt;
  logic [7:0]  bright;
  logic        valid, stuck;

  typedef struct {
    int unsigned hi;
    int unsigned per;
    int unsigned br;
    int unsigned st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pwm_capture #(.CNT_W(12), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .bright    (bright),
    .valid     (valid),
    .stuck     (stuck)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int unsigned h, input int unsigned p, input int unsigned b,
                      input int unsigned st, input int unsigned n);
    exp_t e;
    e.hi = h; e.per = p; e.br = b; e.st = st;
    for (int unsigned i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic pulse(input int unsigned h, input int unsigned l, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic rearm();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic settle(input string tag);
    repeat (6) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  task automatic wait_valid(input int unsigned max, output logic found, output time t);
    found = 1'b0;
    t     = 0;
    for (int unsigned i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        found = 1'b1;
        t     = $time;
      end
    end
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("high_cnt", high_cnt, e.hi);
        check("period_cnt", period_cnt, e.per);
        check("bright", bright, e.br);
        check("stuck", stuck, e.st);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    time  t1, t2;
    int   vcount;

    rst_n = 1'b0; enable = 1'b1; pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_high_cnt", high_cnt, 0);
    check("rst_period_cnt", period_cnt, 0);
    check("rst_bright", bright, 0);
    check("rst_valid", valid, 0);
    check("rst_stuck", stuck, 0);
    rst_n = 1'b1;

    push(5, 16, 5, 0, 3);
    pulse(5, 11, 4);
    settle("drain_5_11");

    rearm();
    push(1000, 2048, 210, 0, 2);
    pulse(1000, 1048, 3);
    settle("drain_led_frame");

    rearm();
    push(4095, 4095, 255, 1, 2);
    pwm_in = 1'b1;
    wait_valid(5000, found, t1);
    check("stuck_first_seen", found, 1);
    wait_valid(5000, found, t2);
    check("stuck_second_seen", found, 1);
    check("stuck_spacing", 32'((t2 - t1) / 10), 4095);
    check("stuck_level", stuck, 1);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    rearm();
    push(100, 200, 82, 0, 2);
    pulse(100, 100, 3);
    settle("drain_100_100");
    check("stuck_cleared", stuck, 0);

    rearm();
    push(30, 50, 30, 0, 2);
    pulse(30, 20, 3);
    enable = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    check("abort_hold_high", high_cnt, 30);
    check("abort_hold_period", period_cnt, 50);
    check("abort_hold_bright", bright, 30);
    enable = 1'b1;
    push(7, 16, 7, 0, 2);
    pulse(7, 9, 3);
    settle("drain_after_abort");

    rearm();
    push(1, 64, 1, 0, 3);
    pulse(1, 63, 4);
    settle("drain_glitch");

    rearm();
    push(10, 4094, 10, 0, 1);
    push(0, 4095, 0, 1, 1);
    push(10, 4094, 10, 0, 1);
    pulse(10, 4084, 1);
    pulse(10, 4085, 1);
    pulse(10, 4084, 1);
    pulse(10, 5, 1);
    settle("drain_limit");

    rearm();
    push(5, 16, 5, 0, 2);
    pulse(5, 11, 2);
    pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    check("pre_reset_drain", sb.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_high_cnt", high_cnt, 0);
    check("async_rst_period_cnt", period_cnt, 0);
    check("async_rst_bright", bright, 0);
    check("async_rst_valid", valid, 0);
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(6, 16, 6, 0, 2);
    pulse(6, 10, 3);
    settle("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
